cdc_tx_scheduler: RTL and testbench

- Source-side controller that shares one multi-bit clock-domain-crossing channel among NREQ requesters.
- Round-robin arbitration; latches the winner's word; drives a 4-phase level req/ack handshake; receives the far-side ack through an internal SYNC_STAGES flop synchroniser.
- Sits in the source domain between peripheral register writers (mapper, APU, joypad shadow regs) and the far-domain capture logic.

---
 rtl/cdc_pkg.sv | 29 ++
 rtl/cdc_ack_sync.sv | 31 +++
 rtl/cdc_tx_scheduler.sv | 163 ++++++++++++++++
 tb/tb_cdc_tx_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and constants for the source-side CDC transfer scheduler.
//   cdc_state_e     : handshake FSM states (IDLE, REQ_HI, REQ_LO).
//   DEF_SYNC_STAGES : default depth of the incoming ack synchroniser.
//   DEF_TIMEOUT_CYC : default per-phase handshake budget (used with CDC_TIMEOUT_EN).
//   clog2()         : ceiling log2, usable in parameter and port width expressions.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } cdc_state_e;

  localparam int unsigned DEF_SYNC_STAGES = 32'd2;
  localparam int unsigned DEF_TIMEOUT_CYC = 32'd1023;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 32'd0;
    v = n - 32'd1;
    while (v != 32'd0) begin
      r = r + 32'd1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_ack_sync.sv
// cdc_ack_sync: STAGES-deep flop synchroniser for a single asynchronous level.
// Ports:
//   clk     in  destination-domain clock
//   rst     in  asynchronous active-high reset (chain clears to 0)
//   async_i in  level from the other clock domain
//   sync_o  out synchronised level, STAGES clock edges after async_i changes
module cdc_ack_sync
  import cdc_pkg::*;
#(
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/cdc_tx_scheduler.sv
// cdc_tx_scheduler: shares one multi-bit CDC channel among NREQ requesters.
// Round-robin picks a requester, latches its word and runs a 4-phase level
// req/ack handshake; the far-side ack is synchronised internally.
// Optional feature macro: CDC_TIMEOUT_EN (per-phase handshake timeout with
// sticky err_timeout). Without it the handshake waits forever and
// err_timeout is tied low.
// Ports:
//   clk, reset  : source clock, asynchronous active-high reset
//   req_valid   : per-requester request, held until req_ready
//   req_data    : packed words, requester i at [i*DW +: DW]
//   req_ready   : one-cycle one-hot accept pulse
//   xfer_data   : word to far domain, stable while xfer_req=1
//   xfer_req    : registered level request to far domain
//   xfer_ack    : asynchronous level ack from far domain
//   busy        : high whenever the FSM is not IDLE
//   grant_idx   : index of the last granted requester
//   err_timeout : sticky handshake-timeout flag
module cdc_tx_scheduler
  import cdc_pkg::*;
#(
  parameter int unsigned NREQ        = 32'd4,
  parameter int unsigned DW          = 32'd8,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [DW-1:0]            xfer_data,
  output logic                     xfer_req,
  input  logic                     xfer_ack,
  output logic                     busy,
  output logic [clog2(NREQ)-1:0]   grant_idx,
  output logic                     err_timeout
);

  localparam int unsigned GW = clog2(NREQ);

  cdc_state_e        state_q;
  logic [GW-1:0]     rr_ptr_q;
  logic [NREQ-1:0]   req_ready_q;
  logic [DW-1:0]     xfer_data_q;
  logic              xfer_req_q;
  logic              busy_q;
  logic [GW-1:0]     grant_idx_q;
  logic              ack_s;
  logic [GW-1:0]     pick_s;

  // First valid index at or above ptr; wraps to the lowest valid index otherwise.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [GW-1:0] ptr);
    logic [NREQ-1:0] upper;
    logic [NREQ-1:0] pool;
    rr_pick = '0;
    upper = v & ~((NREQ'(1) << ptr) - NREQ'(1));
    pool = (upper != '0) ? upper : v;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pool[i]) begin
        rr_pick = GW'(i);
      end
    end
  endfunction

  cdc_ack_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .rst     (reset),
    .async_i (xfer_ack),
    .sync_o  (ack_s)
  );

  assign pick_s = rr_pick(req_valid, rr_ptr_q);

`ifdef CDC_TIMEOUT_EN
  localparam int unsigned CNT_W = clog2(TIMEOUT_CYC + 32'd1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_timeout_q;
  logic             hs_step_s;
  logic             tmo_hit_s;

  // A phase change restarts the budget for the new phase.
  assign hs_step_s = ((state_q == REQ_HI) && ack_s) || ((state_q == REQ_LO) && !ack_s);
  // Fires on the last cycle of the budget so xfer_req is high for exactly TIMEOUT_CYC cycles.
  assign tmo_hit_s = (state_q != IDLE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 32'd1));
  assign err_timeout = err_timeout_q;
`else
  localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
  assign err_timeout = 1'b0;
`endif

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      req_ready_q <= '0;
      xfer_data_q <= '0;
      xfer_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      grant_idx_q <= '0;
`ifdef CDC_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      case (state_q)
        IDLE: begin
          // A still-high synchronised ack is left over from an earlier transfer; wait it out.
          if ((req_valid != '0) && !ack_s) begin
            xfer_data_q <= req_data[int'(pick_s) * DW +: DW];
            grant_idx_q <= pick_s;
            req_ready_q <= NREQ'(1) << pick_s;
            xfer_req_q  <= 1'b1;
            busy_q      <= 1'b1;
            rr_ptr_q    <= (pick_s == GW'(NREQ - 32'd1)) ? '0 : pick_s + GW'(1);
            state_q     <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            xfer_req_q <= 1'b0;
            state_q    <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          xfer_req_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
`ifdef CDC_TIMEOUT_EN
      // Abort overrides whatever the phase logic above decided.
      if (tmo_hit_s) begin
        xfer_req_q    <= 1'b0;
        busy_q        <= 1'b0;
        err_timeout_q <= 1'b1;
        state_q       <= IDLE;
        tmo_cnt_q     <= '0;
      end else if ((state_q == IDLE) || hs_step_s) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign xfer_data = xfer_data_q;
  assign xfer_req  = xfer_req_q;
  assign busy      = busy_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// Self-checking bench for cdc_tx_scheduler: directed scenarios plus randomized
// traffic, checked against a round-robin reference model and a far-side
// ack responder. Build with CDC_TIMEOUT_EN to exercise the timeout path.
module tb_cdc_tx_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int SYNC = 2;
`ifdef CDC_TIMEOUT_EN
  localparam int TMO = 15;
`else
  localparam int TMO = 1023;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [DW-1:0]     xfer_data;
  logic              xfer_req;
  logic              xfer_ack;
  logic              busy;
  logic [1:0]        grant_idx;
  logic              err_timeout;

  // Far side: 0 = manual level, 1 = zero-latency loopback, 2 = delayed loopback.
  int          ack_mode = 0;
  logic        ack_man = 1'b0;
  logic        ack_dly_r = 1'b0;
  int          ack_dly = 3;
  logic [7:0]  hist = '0;

  assign xfer_ack = (ack_mode == 0) ? ack_man : (ack_mode == 1) ? xfer_req : ack_dly_r;

  cdc_tx_scheduler #(
    .NREQ (NREQ), .DW (DW), .SYNC_STAGES (SYNC), .TIMEOUT_CYC (TMO)
  ) dut (
    .clk (clk), .reset (reset), .req_valid (req_valid), .req_data (req_data),
    .req_ready (req_ready), .xfer_data (xfer_data), .xfer_req (xfer_req),
    .xfer_ack (xfer_ack), .busy (busy), .grant_idx (grant_idx),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Round-robin rule: first valid index searching ptr, ptr+1, ... mod NREQ.
  function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  logic [NREQ-1:0]    v_edge = '0;
  logic [NREQ*DW-1:0] d_edge = '0;
  int                 cyc_n = 0;
  int                 mptr = 0;
  int                 glog[$];
  int                 gtim[$];

  // Inputs as the DUT sees them on each rising edge.
  initial forever begin
    @(posedge clk);
    v_edge = req_valid;
    d_edge = req_data;
    cyc_n++;
  end

  // Delayed far-side responder.
  initial forever begin
    @(posedge clk);
    #1;
    hist = {hist[6:0], xfer_req};
    ack_dly_r = hist[ack_dly - 1];
  end

  // Grant scoreboard and data-stability monitor.
  initial begin
    logic [NREQ-1:0] prev_rdy;
    logic            prev_xreq;
    logic [DW-1:0]   held;
    int              pick;
    prev_rdy = '0;
    prev_xreq = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mptr = 0;
        prev_rdy = '0;
        prev_xreq = 1'b0;
      end else begin
        if (req_ready != '0) begin
          pick = model_pick(v_edge, mptr);
          check_eq("rdy_single_cycle", prev_rdy, 0);
          check_eq("rdy_onehot", $countones(req_ready), 1);
          if (pick < 0) begin
            check_eq("grant_without_request", req_ready, 0);
          end else begin
            check_eq("rdy_vec", req_ready, 32'd1 << pick);
            check_eq("grant_idx", grant_idx, pick);
            check_eq("xfer_data_latched", xfer_data, d_edge[pick*DW +: DW]);
            check_eq("xfer_req_on_grant", xfer_req, 1);
            mptr = (pick + 1) % NREQ;
            glog.push_back(pick);
            gtim.push_back(cyc_n);
          end
        end
        if (xfer_req && prev_xreq) check_eq("xfer_data_stable", xfer_data, held);
        held = xfer_data;
        prev_rdy = req_ready;
        prev_xreq = xfer_req;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (12) tick();
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    check_eq(tag, busy, 0);
  endtask

  task automatic wait_grant(input int lim, output int waited);
    waited = 0;
    while (req_ready == '0 && waited < lim) begin
      tick();
      waited++;
    end
  endtask

  initial begin
    int w, cnt, hi, t_au, t_rd, t_ad, data_bad;
    logic pr, pa, ack0, seen2;

    // Reset values.
    repeat (2) tick();
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_xfer_req", xfer_req, 0);
    check_eq("rst_xfer_data", xfer_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_idx", grant_idx, 0);
    check_eq("rst_err_timeout", err_timeout, 0);
    reset = 1'b0;
    repeat (4) tick();

    // Single request with 3-cycle ack loopback.
    ack_mode = 2;
    ack_dly = 3;
    req_data = {8'h5A, 8'h3C, 8'hC3, 8'hA5};
    req_valid = 4'b0001;
    tick();
    check_eq("t1_ready", req_ready, 4'b0001);
    check_eq("t1_busy", busy, 1);
    ack0 = xfer_ack;
    req_valid = '0;
    t_au = -1; t_rd = -1; t_ad = -1; data_bad = 0;
    pr = xfer_req; pa = xfer_ack;
    for (int k = 1; k < 100 && t_ad < 0; k++) begin
      tick();
      if (xfer_req && xfer_data !== 8'hA5) data_bad++;
      if (!pa && xfer_ack && t_au < 0) t_au = k;
      if (pr && !xfer_req && t_rd < 0) t_rd = k;
      if (pa && !xfer_ack && t_au >= 0 && t_ad < 0) t_ad = k;
      pr = xfer_req; pa = xfer_ack;
    end
    check_eq("t1_ack_low_at_req_rise", ack0, 0);
    check_eq("t1_ack_rise_after_req", t_au > 0, 1);
    check_eq("t1_req_fall_after_ack", t_rd > t_au, 1);
    check_eq("t1_ack_fall_after_req_fall", t_ad > t_rd, 1);
    check_eq("t1_data_A5_held", data_bad, 0);
    wait_idle("t1_busy_returns_0");

    // All four continuously valid, zero-latency far side.
    do_reset();
    ack_mode = 1;
    glog.delete();
    gtim.delete();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'hF;
    cnt = 0;
    while (glog.size() < 5 && cnt < 200) begin
      tick();
      cnt++;
    end
    req_valid = '0;
    check_eq("t2_grant_count", glog.size(), 5);
    if (glog.size() >= 5) begin
      for (int i = 0; i < 5; i++) check_eq("t2_order", glog[i], i % NREQ);
      for (int i = 1; i < 5; i++) check_eq("t2_min_period", gtim[i] - gtim[i-1], 2 * SYNC + 3);
    end
    wait_idle("t2_idle");

    // Requester 2 withdraws before its turn; rr pointer now at 1.
    glog.delete();
    seen2 = 1'b0;
    req_data = {8'h9D, 8'h8C, 8'h7B, 8'h6A};
    req_valid = 4'b1110;
    cnt = 0;
    while (glog.size() < 2 && cnt < 200) begin
      tick();
      cnt++;
      if (req_ready[2]) begin seen2 = 1'b1; req_valid[2] = 1'b0; end
      if (req_ready[1]) req_valid = 4'b1000;
      if (req_ready[3]) req_valid[3] = 1'b0;
    end
    req_valid = '0;
    check_eq("t3_grant_count", glog.size(), 2);
    if (glog.size() >= 2) begin
      check_eq("t3_first", glog[0], 1);
      check_eq("t3_second", glog[1], 3);
    end
    check_eq("t3_no_ready2", seen2, 0);
    wait_idle("t3_idle");

    // Reset in REQ_HI while far side holds ack high.
    do_reset();
    ack_mode = 0;
    ack_man = 1'b0;
    req_valid = 4'b0001;
    wait_grant(20, w);
    check_eq("t4_grant", req_ready, 4'b0001);
    req_valid = '0;
    ack_man = 1'b1;
    tick();
    check_eq("t4_in_req_hi", xfer_req, 1);
    reset = 1'b1;
    #1;
    check_eq("t4_async_xfer_req", xfer_req, 0);
    check_eq("t4_async_busy", busy, 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    req_valid = 4'b0001;
    cnt = 0;
    repeat (5) begin
      tick();
      if (req_ready != '0 || busy) cnt++;
    end
    check_eq("t4_no_grant_stale_ack", cnt, 0);
    ack_man = 1'b0;
    wait_grant(20, w);
    check_eq("t4_grant_after_ack_low", req_ready, 4'b0001);
    check_eq("t4_grant_latency", w, SYNC + 1);
    req_valid = '0;
    ack_dly = 2;
    ack_mode = 2;
    wait_idle("t4_idle");

    // One-cycle ack glitch in IDLE with no requests.
    ack_mode = 0;
    ack_man = 1'b0;
    repeat (3) tick();
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    cnt = 0;
    repeat (8) begin
      tick();
      if (xfer_req || busy || req_ready != '0) cnt++;
    end
    check_eq("t5_glitch_ignored", cnt, 0);

    // Far side never acks.
    req_valid = 4'b0001;
    wait_grant(20, w);
    check_eq("t6_grant", req_ready, 4'b0001);
    req_valid = '0;
    hi = 0;
`ifdef CDC_TIMEOUT_EN
    while (xfer_req && hi < 2000) begin
      hi++;
      tick();
    end
    check_eq("t6_timeout_len", hi, TMO);
    check_eq("t6_err_set", err_timeout, 1);
    check_eq("t6_busy_after_abort", busy, 0);
    repeat (20) tick();
    check_eq("t6_err_sticky", err_timeout, 1);
    do_reset();
    check_eq("t6_err_cleared_by_reset", err_timeout, 0);
`else
    while (xfer_req && hi < 1000) begin
      hi++;
      tick();
    end
    check_eq("t6_req_held", hi, 1000);
    check_eq("t6_no_err", err_timeout, 0);
    ack_mode = 2;
    wait_idle("t6_idle");
`endif

    // Randomized traffic against the round-robin model.
    do_reset();
    for (int seg = 0; seg < 3; seg++) begin
      ack_dly = 1 + 2 * seg;
      ack_mode = (seg == 0) ? 1 : 2;
      glog.delete();
      repeat (500) begin
        tick();
        for (int i = 0; i < NREQ; i++) begin
          if (req_ready[i]) begin
            req_valid[i] = 1'b0;
          end else if (!req_valid[i]) begin
            if ($urandom_range(3) == 0) begin
              req_data[i*DW +: DW] = DW'($urandom);
              req_valid[i] = 1'b1;
            end
          end else if ($urandom_range(15) == 0) begin
            req_valid[i] = 1'b0;
          end
        end
      end
      req_valid = '0;
      wait_idle("t7_idle");
      check_eq("t7_activity", glog.size() > 10, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
